// File: rtl/linebuffer_window.sv
// linebuffer_window
//   Single-line pixel buffer for the sliding-window filter path. One image
//   line of LINE_LEN pixels is held in a circular array indexed by column.
//   Each accepted read returns a TAPS-pixel horizontal window. The window is
//   padded at the right edge of the line and never wraps into the next line.
//
// Parameters
//   DATA_W   : bits per pixel
//   LINE_LEN : pixels per line / storage depth (>= TAPS)
//   TAPS     : pixels per output window (>= 1)
//   PAD_MODE : right-edge fill, 0 = replicate last pixel, 1 = zero
//
// Ports
//   i_clk, i_rst    : clock (rising edge), asynchronous active-high reset
//   i_flush         : synchronous clear of pointers, count and outputs
//   i_data          : pixel to write
//   i_data_valid    : write request
//   o_wr_ready      : space available (count < LINE_LEN)
//   i_rd_data       : window read request
//   o_rd_avail      : window at the read column is fully written
//   o_data          : registered window, tap 0 in the MSBs
//   o_data_valid    : one-cycle strobe, o_data updated
//   o_count         : pixels written but not yet retired
//   o_overflow      : sticky, write attempted while not ready
//   o_underflow     : sticky, read attempted while not available
module linebuffer_window #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int TAPS     = 3,
  parameter int PAD_MODE = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_data_valid,
  output logic                          o_wr_ready,
  input  logic                          i_rd_data,
  output logic                          o_rd_avail,
  output logic [TAPS*DATA_W-1:0]        o_data,
  output logic                          o_data_valid,
  output logic [$clog2(LINE_LEN+1)-1:0] o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int CNT_W  = $clog2(LINE_LEN + 1);
  localparam int ADDR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  // Wide enough for rd_col + k, which can reach LINE_LEN + TAPS - 2.
  localparam int EXT_W  = CNT_W + 1;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0]  LEN_C    = CNT_W'(LINE_LEN);
  localparam logic [CNT_W-1:0]  TAPS_C   = CNT_W'(TAPS);
  localparam logic [EXT_W-1:0]  LEN_X    = EXT_W'(LINE_LEN);

  logic [DATA_W-1:0]      mem [LINE_LEN];

  logic [ADDR_W-1:0]      wr_col_reg, wr_col_next;
  logic [ADDR_W-1:0]      rd_col_reg, rd_col_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [TAPS*DATA_W-1:0] data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic                   ovf_reg, ovf_next;
  logic                   unf_reg, unf_next;

  logic [CNT_W-1:0]       remain;
  logic [CNT_W-1:0]       need;
  logic [TAPS*DATA_W-1:0] window;
  logic [DATA_W-1:0]      pad_pix;
  logic                   wr_acc;
  logic                   rd_acc;

  // Near the right edge fewer than TAPS real pixels exist, so only those
  // need to be present before the (padded) window may be read.
  assign remain = LEN_C - CNT_W'(rd_col_reg);
  assign need   = (remain < TAPS_C) ? remain : TAPS_C;

  assign o_wr_ready = (count_reg < LEN_C);
  assign o_rd_avail = (count_reg >= need);

  // Flush overrides both requests.
  assign wr_acc = i_data_valid & o_wr_ready & ~i_flush;
  assign rd_acc = i_rd_data & o_rd_avail & ~i_flush;

  generate
    if (PAD_MODE == 0) begin : g_pad_rep
      assign pad_pix = mem[LAST_COL];
    end else begin : g_pad_zero
      assign pad_pix = '0;
    end
  endgenerate

  // Window assembly: tap k reads column rd_col+k, or the pad value once the
  // column runs past the end of the line.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      logic [EXT_W-1:0] col;
      assign col = EXT_W'(rd_col_reg) + EXT_W'(gi);
      assign window[(TAPS-1-gi)*DATA_W +: DATA_W] =
        (col < LEN_X) ? mem[col[ADDR_W-1:0]] : pad_pix;
    end
  endgenerate

  // Storage is not reset; count alone decides which slots are meaningful.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_col_reg] <= i_data;
    end
  end

  always_comb begin
    wr_col_next = wr_col_reg;
    rd_col_next = rd_col_reg;
    count_next  = count_reg;
    data_next   = data_reg;
    valid_next  = 1'b0;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    if (i_flush) begin
      wr_col_next = '0;
      rd_col_next = '0;
      count_next  = '0;
      data_next   = '0;
    end else begin
      if (i_data_valid && !o_wr_ready) begin
        ovf_next = 1'b1;
      end
      if (i_rd_data && !o_rd_avail) begin
        unf_next = 1'b1;
      end
      if (wr_acc) begin
        wr_col_next = (wr_col_reg == LAST_COL) ? '0 : wr_col_reg + 1'b1;
      end
      if (rd_acc) begin
        rd_col_next = (rd_col_reg == LAST_COL) ? '0 : rd_col_reg + 1'b1;
        data_next   = window;
        valid_next  = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_col_reg <= '0;
      rd_col_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      wr_col_reg <= wr_col_next;
      rd_col_reg <= rd_col_next;
      count_reg  <= count_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  assign o_data       = data_reg;
  assign o_data_valid = valid_reg;
  assign o_count      = count_reg;
  assign o_overflow   = ovf_reg;
  assign o_underflow  = unf_reg;

endmodule

// File: tb/tb_linebuffer_window.sv
// Bench for linebuffer_window. Three instances run side by side:
//   inst0 : defaults (LINE_LEN=512, TAPS=3, PAD_MODE=0)
//   inst1 : LINE_LEN=8, TAPS=3, PAD_MODE=0
//   inst2 : LINE_LEN=8, TAPS=3, PAD_MODE=1
// Every cycle all outputs of all instances are compared with a behavioural
// model; directed steps add fixed expected values from the test plan.
module tb_linebuffer_window;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush [3];
  logic        dv    [3];
  logic        rd    [3];
  logic [7:0]  din   [3];
  logic        wr_rdy[3];
  logic        rd_av [3];
  logic        dval  [3];
  logic        ovf   [3];
  logic        unf   [3];
  logic [23:0] dout  [3];
  logic [9:0]  cnt_a;
  logic [3:0]  cnt_b;
  logic [3:0]  cnt_c;

  linebuffer_window #(.DATA_W(8), .LINE_LEN(512), .TAPS(3), .PAD_MODE(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[0]), .i_data(din[0]),
    .i_data_valid(dv[0]), .o_wr_ready(wr_rdy[0]), .i_rd_data(rd[0]),
    .o_rd_avail(rd_av[0]), .o_data(dout[0]), .o_data_valid(dval[0]),
    .o_count(cnt_a), .o_overflow(ovf[0]), .o_underflow(unf[0]));

  linebuffer_window #(.DATA_W(8), .LINE_LEN(8), .TAPS(3), .PAD_MODE(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[1]), .i_data(din[1]),
    .i_data_valid(dv[1]), .o_wr_ready(wr_rdy[1]), .i_rd_data(rd[1]),
    .o_rd_avail(rd_av[1]), .o_data(dout[1]), .o_data_valid(dval[1]),
    .o_count(cnt_b), .o_overflow(ovf[1]), .o_underflow(unf[1]));

  linebuffer_window #(.DATA_W(8), .LINE_LEN(8), .TAPS(3), .PAD_MODE(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[2]), .i_data(din[2]),
    .i_data_valid(dv[2]), .o_wr_ready(wr_rdy[2]), .i_rd_data(rd[2]),
    .o_rd_avail(rd_av[2]), .o_data(dout[2]), .o_data_valid(dval[2]),
    .o_count(cnt_c), .o_overflow(ovf[2]), .o_underflow(unf[2]));

  // Behavioural model state
  int m_len [3] = '{512, 8, 8};
  int m_pad [3] = '{0, 0, 1};
  int m_mem [3][512];
  int m_wr [3], m_rd [3], m_cnt [3], m_data [3], m_val [3];
  int m_ovf [3], m_unf [3], last_col [3];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d got=%0h exp=%0h", tag, i, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_cnt(input int i);
    case (i)
      0:       return {22'd0, cnt_a};
      1:       return {28'd0, cnt_b};
      default: return {28'd0, cnt_c};
    endcase
  endfunction

  // Pixels still needed at the read column: a full window, or whatever is
  // left of the line.
  function automatic int need_of(input int i);
    int n;
    n = m_len[i] - m_rd[i];
    return (n < 3) ? n : 3;
  endfunction

  function automatic int window_of(input int i);
    int w, c, p;
    w = 0;
    for (int k = 0; k < 3; k++) begin
      c = m_rd[i] + k;
      if (c < m_len[i]) p = m_mem[i][c];
      else if (m_pad[i] == 1) p = 0;
      else p = m_mem[i][m_len[i]-1];
      w = (w << 8) | p;
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_wr[i] = 0; m_rd[i] = 0; m_cnt[i] = 0; m_data[i] = 0;
      m_val[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; last_col[i] = -1;
    end
  endtask

  task automatic clear_in();
    for (int i = 0; i < 3; i++) begin
      flush[i] = 1'b0; dv[i] = 1'b0; rd[i] = 1'b0; din[i] = 8'h00;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("o_data",       i, {8'd0, dout[i]}, m_data[i]);
      chk("o_data_valid", i, {31'd0, dval[i]}, m_val[i]);
      chk("o_count",      i, obs_cnt(i), m_cnt[i]);
      chk("o_overflow",   i, {31'd0, ovf[i]}, m_ovf[i]);
      chk("o_underflow",  i, {31'd0, unf[i]}, m_unf[i]);
      chk("o_wr_ready",   i, {31'd0, wr_rdy[i]}, (m_cnt[i] < m_len[i]) ? 1 : 0);
      chk("o_rd_avail",   i, {31'd0, rd_av[i]}, (m_cnt[i] >= need_of(i)) ? 1 : 0);
    end
  endtask

  // Apply the current inputs for one clock, advance the model, check.
  task automatic step();
    bit wa, ra, wok, av;
    for (int i = 0; i < 3; i++) begin
      if (flush[i] === 1'b1) begin
        m_wr[i] = 0; m_rd[i] = 0; m_cnt[i] = 0; m_data[i] = 0; m_val[i] = 0;
      end else begin
        wok = (m_cnt[i] < m_len[i]);
        av  = (m_cnt[i] >= need_of(i));
        wa  = (dv[i] === 1'b1) && wok;
        ra  = (rd[i] === 1'b1) && av;
        if ((dv[i] === 1'b1) && !wok) m_ovf[i] = 1;
        if ((rd[i] === 1'b1) && !av)  m_unf[i] = 1;
        m_val[i] = 0;
        if (ra) begin
          m_data[i]   = window_of(i);
          m_val[i]    = 1;
          last_col[i] = m_rd[i];
          m_rd[i]     = (m_rd[i] + 1) % m_len[i];
        end
        if (wa) begin
          m_mem[i][m_wr[i]] = int'(din[i]);
          m_wr[i] = (m_wr[i] + 1) % m_len[i];
        end
        m_cnt[i] = m_cnt[i] + int'(wa) - int'(ra);
      end
    end
    @(posedge clk);
    #1;
    check_all();
    clear_in();
  endtask

  task automatic both_wr(input logic [7:0] v);
    dv[1] = 1'b1; din[1] = v;
    dv[2] = 1'b1; din[2] = v;
  endtask

  task automatic both_rd();
    rd[1] = 1'b1;
    rd[2] = 1'b1;
  endtask

  task automatic random_steps(input int n);
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < 3; i++) begin
        dv[i]    = 1'($urandom_range(0, 1));
        din[i]   = 8'($urandom_range(0, 255));
        rd[i]    = 1'($urandom_range(0, 1));
        flush[i] = ($urandom_range(0, 31) == 0);
      end
      step();
    end
  endtask

  initial begin
    clear_in();
    model_reset();
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 512; a++) m_mem[i][a] = 0;

    // Reset is asynchronous: outputs settle before any clock edge.
    rst = 1'b1;
    #2;
    check_all();
    for (int i = 0; i < 3; i++) begin
      chk("rst_wr_ready", i, {31'd0, wr_rdy[i]}, 1);
      chk("rst_rd_avail", i, {31'd0, rd_av[i]}, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Underflow: two pixels at rd_col 0 are not enough for a 3-tap window.
    both_wr(8'h01); step();
    both_wr(8'h02); step();
    both_rd(); step();
    for (int i = 1; i < 3; i++) begin
      chk("underflow_no_strobe", i, {31'd0, dval[i]}, 0);
      chk("underflow_flag", i, {31'd0, unf[i]}, 1);
    end
    both_wr(8'h03); step();
    both_wr(8'h04); step();
    both_wr(8'h05); step();
    // Simultaneous write and read at count 5.
    both_wr(8'h06); both_rd(); step();
    for (int i = 1; i < 3; i++) begin
      chk("simul_count", i, obs_cnt(i), 5);
      chk("simul_window", i, {8'd0, dout[i]}, 32'h010203);
    end
    // Move to rd_col 4, count 3, then flush alongside a write.
    repeat (3) begin both_rd(); step(); end
    both_wr(8'h07); step();
    flush[1] = 1'b1; flush[2] = 1'b1; both_wr(8'h08); step();
    for (int i = 1; i < 3; i++) begin
      chk("flush_count", i, obs_cnt(i), 0);
      chk("flush_data", i, {8'd0, dout[i]}, 0);
      chk("flush_keep_unf", i, {31'd0, unf[i]}, 1);
      chk("flush_keep_ovf", i, {31'd0, ovf[i]}, 0);
    end

    // Fill to full, ninth pixel dropped.
    for (int v = 8'h10; v <= 8'h18; v++) begin both_wr(8'(v)); step(); end
    for (int i = 1; i < 3; i++) begin
      chk("full_count", i, obs_cnt(i), 8);
      chk("full_wr_ready", i, {31'd0, wr_rdy[i]}, 0);
      chk("full_overflow", i, {31'd0, ovf[i]}, 1);
    end
    both_rd(); step();
    for (int i = 1; i < 3; i++) begin
      chk("after_read_count", i, obs_cnt(i), 7);
      chk("after_read_wr_ready", i, {31'd0, wr_rdy[i]}, 1);
      chk("first_window", i, {8'd0, dout[i]}, 32'h101112);
    end
    // Read out to the right edge.
    for (int r = 0; r < 7; r++) begin
      both_rd(); step();
      if (last_col[1] == 6) begin
        chk("edge6_pad0", 1, {8'd0, dout[1]}, 32'h161717);
        chk("edge6_pad1", 2, {8'd0, dout[2]}, 32'h161700);
      end
      if (last_col[1] == 7) begin
        chk("edge7_pad0", 1, {8'd0, dout[1]}, 32'h171717);
        chk("edge7_pad1", 2, {8'd0, dout[2]}, 32'h170000);
      end
    end
    // rd_col has wrapped to 0: next window comes from the start of the line.
    both_wr(8'h20); step();
    both_wr(8'h21); step();
    both_wr(8'h22); step();
    both_rd(); step();
    for (int i = 1; i < 3; i++) begin
      chk("wrap_col", i, last_col[i], 0);
      chk("wrap_window", i, {8'd0, dout[i]}, 32'h202122);
    end

    // Default instance: fill and stream a full line.
    for (int p = 0; p < 512; p++) begin
      dv[0] = 1'b1; din[0] = 8'(p % 256);
      if (m_cnt[0] >= need_of(0)) rd[0] = 1'b1;
      step();
      if (m_val[0] == 1 && last_col[0] == 0)  chk("stream_col0",  0, {8'd0, dout[0]}, 32'h000102);
      if (m_val[0] == 1 && last_col[0] == 10) chk("stream_col10", 0, {8'd0, dout[0]}, 32'h0A0B0C);
    end
    for (int g = 0; g < 16 && m_cnt[0] > 0; g++) begin
      rd[0] = 1'b1;
      step();
      if (m_val[0] == 1 && last_col[0] == 511) chk("stream_col511", 0, {8'd0, dout[0]}, 32'hFFFFFF);
    end
    chk("stream_drained", 0, obs_cnt(0), 0);

    random_steps(600);

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    random_steps(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/linebuffer_window.md
# linebuffer_window

Parametrised single-line pixel buffer for the sliding-window filter path. It stores one image line of `LINE_LEN` pixels in a circular array and delivers a `TAPS`-pixel horizontal window per read. Beyond the base line buffer, it adds:
- occupancy-based read/write handshakes;
- right-edge padding instead of pointer wrap;
- a registered output with a valid strobe;
- sticky error flags;
- a synchronous flush.

Several instances are stacked to feed the row-combining convolution stage.

## Interface
- `DATA_W`, 8 — bits per pixel.
- `LINE_LEN`, 512 — pixels per line, which is also the storage depth. Must be ≥ `TAPS`.
- `TAPS`, 3 — pixels per output window, ≥ 1.
- `PAD_MODE`, 0 — right-edge fill. 0 replicates pixel `LINE_LEN-1`; 1 inserts zero.

- `i_clk`  in  1  — single clock, rising edge.
- `i_rst`  in  1  — reset, asynchronous, active-high.
- `i_flush`  in  1  — synchronous clear of pointers, count and outputs. Does not clear error flags.
- `i_data`  in  `DATA_W`  — pixel to write.
- `i_data_valid`  in  1  — write request.
- `o_wr_ready`  out  1  — space available, `count < LINE_LEN`.
- `i_rd_data`  in  1  — window read request.
- `o_rd_avail`  out  1  — current window is fully written.
- `o_data`  out  `TAPS*DATA_W`  — registered window. The pixel at column `rd_col` is in the MSBs, `rd_col+TAPS-1` in the LSBs.
- `o_data_valid`  out  1  — one-cycle strobe: `o_data` updated.
- `o_count`  out  `clog2(LINE_LEN+1)`  — pixels written but not yet retired.
- `o_overflow`  out  1  — sticky: a write was attempted while `o_wr_ready`=0.
- `o_underflow`  out  1  — sticky: a read was attempted while `o_rd_avail`=0.

## Operation
- **State.**
  - `wr_col` and `rd_col` each run 0..`LINE_LEN-1` and wrap to 0 after `LINE_LEN-1`. Non-power-of-2 `LINE_LEN` must wrap correctly.
  - The storage address equals the column.
  - `count` holds 0..`LINE_LEN`.
- **Write accept** = `i_data_valid & o_wr_ready`. Store `i_data` at `wr_col`, then advance `wr_col`.
- **Write reject** = `i_data_valid & ~o_wr_ready`. Drop the pixel and set `o_overflow`.
- **`need`** = min(`TAPS`, `LINE_LEN - rd_col`).
- **`o_rd_avail`** = (`count ≥ need`). This is combinational from registered state.
- **Read accept** = `i_rd_data & o_rd_avail`.
  - For each k in 0..`TAPS-1`: if `rd_col+k < LINE_LEN`, tap k = `mem[rd_col+k]`. Otherwise tap k = `mem[LINE_LEN-1]` (`PAD_MODE`=0) or 0 (`PAD_MODE`=1). Taps never wrap into the next line.
  - The taps are registered into `o_data`, `o_data_valid`=1 next cycle, `rd_col` advances, and `count` decrements by 1.
- **Read reject** = `i_rd_data & ~o_rd_avail`. `o_data` is unchanged, no strobe, and `o_underflow` is set.
- **Write and read accepted in the same cycle.** `count` is unchanged. The write slot is never a slot the read window uses, because `count < LINE_LEN` guarantees this. `o_wr_ready` does not look ahead at a same-cycle read.
- **`i_flush`.**
  - Clears `wr_col`, `rd_col`, `count`, `o_data` and `o_data_valid` on the next edge.
  - Takes priority over a same-cycle read or write; both are ignored and neither sets an error flag.
  - Memory contents are not cleared.
- **`i_rst`.** Asserting it at any time, including mid-line, immediately forces all registers to their reset values.

## Timing
- Reset values:
  - `o_data`=0, `o_data_valid`=0, `o_count`=0, `o_overflow`=0, `o_underflow`=0.
  - `o_wr_ready`=1 and `o_rd_avail`=0, as derived from `count`=0.
- Write: a pixel accepted at edge N is readable in a window evaluated after edge N. `o_rd_avail` may rise in cycle N+1.
- Read: a request accepted at edge N produces `o_data` and `o_data_valid` at edge N+1. Latency is 1 cycle. One window per cycle can be sustained.
- `o_data` holds its value between strobes. `o_data_valid` is high for exactly one cycle per accepted read.
- Sticky flags set at the edge that sees the bad request and clear only on `i_rst`.
- `o_count` updates on the accepting edge. Write-only gives +1, read-only gives −1, both or neither gives 0.
- Deassertion of `i_rst` must be synchronised externally. The block makes no timing assumptions relative to the first edge.

## Test plan
- **Reset and idle.** Assert `i_rst` asynchronously mid-cycle → all outputs go to reset values immediately. Then `o_wr_ready`=1, `o_rd_avail`=0, `o_count`=0.
- **Fill and stream.** Defaults. Write pixels 0..511 (value = col mod 256) and read on each cycle `o_rd_avail`=1 → the window at `rd_col`=0 is 0x000102, `rd_col`=10 gives 0x0A0B0C, and each `o_data_valid` lags its read by 1 cycle.
- **Right edge.** `LINE_LEN`=8, `TAPS`=3, pixels 0x10..0x17:
  - `PAD_MODE`=0: `rd_col`=6 gives 0x161717; `rd_col`=7 gives 0x171717.
  - `PAD_MODE`=1: `rd_col`=6 gives 0x161700; `rd_col`=7 gives 0x170000.
  - In both modes `rd_col` wraps to 0 after 7.
- **Full/overflow.** `LINE_LEN`=8. Write 9 pixels with no reads → `o_count`=8, `o_wr_ready`=0, the 9th pixel is dropped and `o_overflow`=1. After one read, `o_count`=7 and `o_wr_ready`=1.
- **Underflow and simultaneous events.**
  - Read with `count`=2 at `rd_col`=0 and `TAPS`=3 → no strobe and `o_underflow`=1.
  - Write and read in the same cycle with `count`=5 → `count` stays 5 and the window is correct.
- **Flush mid-line.** At `rd_col`=4, `count`=3, pulse `i_flush` together with `i_data_valid` → `count`=0, `rd_col`=`wr_col`=0, the write is ignored, and `o_overflow`/`o_underflow` keep their prior values.
